sc_reg_counter_general: RTL and testbench
=========================================

// Module: sc_reg_counter_general
// PURPOSE
//  Parametrised general-purpose up/down counter register: the successor to the fixed 4-bit incrementer.
//  Adds:
//   - configurable width
//   - runtime upper limit
//   - wrap or saturate mode
//   - synchronous clear and parallel load
//   - enable prescaler
//   - terminal-count pulse and sticky overflow flag
//  Used for game counters: score, speed steps, lap/timer ticks, driven from the 50 MHz domain.
// PARAMETERS
//  RegGENERAL_DATAWIDTH  4  width of count, load and limit buses
//  RegGENERAL_RESETVAL   0  value loaded on reset and on clear; must be <= 2^W-1
//  RegGENERAL_PRESCALE   1  enabled cycles per count step; >=1; 1 = step on every enabled cycle
// PORTS
//  SC_RegGENERAL_CLOCK_50        in   1  system clock, all state on rising edge
//  SC_RegGENERAL_RESET_InHigh    in   1  asynchronous, active-high reset
//  SC_RegGENERAL_clear_InHigh    in   1  synchronous clear to RESETVAL
//  SC_RegGENERAL_load_InHigh     in   1  synchronous parallel load
//  SC_RegGENERAL_load_InBUS      in   W  value to load
//  SC_RegGENERAL_enable_InHigh   in   1  count enable, feeds prescaler
//  SC_RegGENERAL_upnDown_InHigh  in   1  1 = count up, 0 = count down
//  SC_RegGENERAL_sat_InHigh      in   1  1 = saturate at bounds, 0 = wrap
//  SC_RegGENERAL_limit_InBUS     in   W  upper bound of count range [0..limit]
//  SC_RegGENERAL_data_OutBUS     out  W  registered count value
//  SC_RegGENERAL_tc_OutHigh      out  1  1-cycle pulse: step attempted at a bound
//  SC_RegGENERAL_ovf_OutHigh     out  1  sticky: any bound hit since last clear/reset
// BEHAVIOUR
//  Reset (async):
//   - data=RESETVAL, tc=0, ovf=0, prescale count=0.
//   - Reset asserted mid-operation overrides everything on the same edge.
//  Priority per clock edge: clear > load > step > hold.
//  clear:
//   - data=RESETVAL, ovf=0, tc=0, prescale count=0.
//  load:
//   - data=load_InBUS, accepted even if > limit.
//   - prescale count=0, tc=0; ovf unchanged.
//  Prescaler:
//   - Counts enabled cycles 0..PRESCALE-1.
//   - Step fires on the enabled cycle where prescale count==PRESCALE-1; prescale count then returns to 0.
//   - enable=0: prescale count holds, data holds, tc=0.
//  Step, up:
//   - data<limit: data+1.
//   - data>=limit: wrap gives 0, saturate gives limit. tc=1, ovf=1.
//  Step, down:
//   - data>limit: data=limit, no tc.
//   - 0<data<=limit: data-1.
//   - data==0: wrap gives limit, saturate holds 0. tc=1, ovf=1.
//  Arithmetic:
//   - Unsigned, W bits; no carry escapes.
//   - limit=0 means every step is at a bound: value stays 0 and tc pulses on every step.
//  Latency:
//   - data, tc and ovf are registered.
//   - Each shows its new value 1 cycle after the triggering edge.
//   - tc is high for exactly the cycle in which data shows the wrapped or saturated value.
//  Runtime changes:
//   - limit, mode and direction may change on any cycle.
//   - They take effect at the next step; no glitch on outputs.
// TESTING
//  1. W=4, PRESCALE=1, limit=9, up, wrap, enable=1 for 12 cycles -> data 1..9, 0, 1, 2; tc high once, with data=0; ovf=1.
//  2. limit=9, up, sat, load 8, then 3 steps -> data 9, 9, 9; tc high on the 2nd and 3rd steps; ovf=1.
//  3. Down, wrap, limit=5, from 0 -> data 5, tc=1. Load 12 with limit=5, then down step -> data 5, tc=0.
//  4. PRESCALE=3, enable=1 for 9 cycles from 0, limit=15 -> data steps 1, 2, 3 on the 3rd, 6th and 9th cycles; enable low mid-count holds the phase.
//  5. clear and load asserted together with ovf=1 and data=7 -> data=RESETVAL, ovf=0; load ignored.
//  6. Async reset pulse between clock edges mid-count -> data=RESETVAL, tc=0, ovf=0 immediately; counting resumes from 0 after release.

Source files
------------

// File: rtl/sc_reg_counter_general.sv
// General-purpose up/down counter register with runtime limit, wrap/saturate mode,
// clear/load, enable prescaler, terminal-count pulse and sticky overflow flag.
module sc_reg_counter_general #(
    parameter int RegGENERAL_DATAWIDTH = 4,
    parameter int RegGENERAL_RESETVAL  = 0,
    parameter int RegGENERAL_PRESCALE  = 1
) (
    input  logic                            SC_RegGENERAL_CLOCK_50,
    input  logic                            SC_RegGENERAL_RESET_InHigh,
    input  logic                            SC_RegGENERAL_clear_InHigh,
    input  logic                            SC_RegGENERAL_load_InHigh,
    input  logic [RegGENERAL_DATAWIDTH-1:0] SC_RegGENERAL_load_InBUS,
    input  logic                            SC_RegGENERAL_enable_InHigh,
    input  logic                            SC_RegGENERAL_upnDown_InHigh,
    input  logic                            SC_RegGENERAL_sat_InHigh,
    input  logic [RegGENERAL_DATAWIDTH-1:0] SC_RegGENERAL_limit_InBUS,
    output logic [RegGENERAL_DATAWIDTH-1:0] SC_RegGENERAL_data_OutBUS,
    output logic                            SC_RegGENERAL_tc_OutHigh,
    output logic                            SC_RegGENERAL_ovf_OutHigh
);

    localparam int W  = RegGENERAL_DATAWIDTH;
    localparam int PW = (RegGENERAL_PRESCALE > 1) ? $clog2(RegGENERAL_PRESCALE) : 1;
    localparam logic [W-1:0]  RESET_VAL = W'(RegGENERAL_RESETVAL);
    localparam logic [W-1:0]  ZERO      = {W{1'b0}};
    localparam logic [W-1:0]  ONE       = W'(1'b1);
    localparam logic [PW-1:0] PRE_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PRE_ONE   = PW'(1'b1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(RegGENERAL_PRESCALE - 1);

    logic [W-1:0]  data_r, data_next_s, step_data_s;
    logic [PW-1:0] pre_r, pre_next_s;
    logic          tc_r, tc_next_s;
    logic          ovf_r, ovf_next_s;
    logic          step_hit_s;

    // Value a single step would produce from the current count; a value above the
    // limit counts as "at the bound" going up and snaps to the limit going down.
    always_comb begin
        step_data_s = data_r;
        step_hit_s  = 1'b0;
        if (SC_RegGENERAL_upnDown_InHigh) begin
            if (data_r < SC_RegGENERAL_limit_InBUS) begin
                step_data_s = data_r + ONE;
            end else begin
                step_data_s = SC_RegGENERAL_sat_InHigh ? SC_RegGENERAL_limit_InBUS : ZERO;
                step_hit_s  = 1'b1;
            end
        end else begin
            if (data_r > SC_RegGENERAL_limit_InBUS) begin
                step_data_s = SC_RegGENERAL_limit_InBUS;
            end else if (data_r == ZERO) begin
                step_data_s = SC_RegGENERAL_sat_InHigh ? ZERO : SC_RegGENERAL_limit_InBUS;
                step_hit_s  = 1'b1;
            end else begin
                step_data_s = data_r - ONE;
            end
        end
    end

    // Next-state selection: clear > load > prescaled step > hold.
    always_comb begin
        data_next_s = data_r;
        pre_next_s  = pre_r;
        tc_next_s   = 1'b0;
        ovf_next_s  = ovf_r;
        if (SC_RegGENERAL_clear_InHigh) begin
            data_next_s = RESET_VAL;
            pre_next_s  = PRE_ZERO;
            ovf_next_s  = 1'b0;
        end else if (SC_RegGENERAL_load_InHigh) begin
            data_next_s = SC_RegGENERAL_load_InBUS;
            pre_next_s  = PRE_ZERO;
        end else if (SC_RegGENERAL_enable_InHigh) begin
            if (pre_r == PRE_LAST) begin
                pre_next_s  = PRE_ZERO;
                data_next_s = step_data_s;
                tc_next_s   = step_hit_s;
                ovf_next_s  = ovf_r | step_hit_s;
            end else begin
                pre_next_s  = pre_r + PRE_ONE;
            end
        end else begin
            pre_next_s = pre_r;
        end
    end

    // State and output registers.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            data_r <= RESET_VAL;
            pre_r  <= PRE_ZERO;
            tc_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            data_r <= data_next_s;
            pre_r  <= pre_next_s;
            tc_r   <= tc_next_s;
            ovf_r  <= ovf_next_s;
        end
    end

    assign SC_RegGENERAL_data_OutBUS = data_r;
    assign SC_RegGENERAL_tc_OutHigh  = tc_r;
    assign SC_RegGENERAL_ovf_OutHigh = ovf_r;

endmodule

// File: tb/tb_sc_reg_counter_general.sv
// Bench for sc_reg_counter_general: two instances (prescale 1 and 3) driven in
// parallel, checked against an integer reference model plus directed scenarios.
module tb_sc_reg_counter_general;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0;
    logic [3:0] ld_bus = 4'd0, lim_bus = 4'd9;
    logic [3:0] d0, d1;
    logic       tc0, tc1, ovf0, ovf1;

    int total = 0;
    int bad   = 0;

    int md[2], mt[2], mo[2], mp[2];
    int presc[2] = '{1, 3};
    int rval[2]  = '{0, 2};

    always #10 clk = ~clk;

    sc_reg_counter_general #(.RegGENERAL_DATAWIDTH(4), .RegGENERAL_RESETVAL(0), .RegGENERAL_PRESCALE(1)) dut0 (
        .SC_RegGENERAL_CLOCK_50(clk), .SC_RegGENERAL_RESET_InHigh(rst),
        .SC_RegGENERAL_clear_InHigh(clr), .SC_RegGENERAL_load_InHigh(ld),
        .SC_RegGENERAL_load_InBUS(ld_bus), .SC_RegGENERAL_enable_InHigh(en),
        .SC_RegGENERAL_upnDown_InHigh(up), .SC_RegGENERAL_sat_InHigh(sat),
        .SC_RegGENERAL_limit_InBUS(lim_bus), .SC_RegGENERAL_data_OutBUS(d0),
        .SC_RegGENERAL_tc_OutHigh(tc0), .SC_RegGENERAL_ovf_OutHigh(ovf0));

    sc_reg_counter_general #(.RegGENERAL_DATAWIDTH(4), .RegGENERAL_RESETVAL(2), .RegGENERAL_PRESCALE(3)) dut1 (
        .SC_RegGENERAL_CLOCK_50(clk), .SC_RegGENERAL_RESET_InHigh(rst),
        .SC_RegGENERAL_clear_InHigh(clr), .SC_RegGENERAL_load_InHigh(ld),
        .SC_RegGENERAL_load_InBUS(ld_bus), .SC_RegGENERAL_enable_InHigh(en),
        .SC_RegGENERAL_upnDown_InHigh(up), .SC_RegGENERAL_sat_InHigh(sat),
        .SC_RegGENERAL_limit_InBUS(lim_bus), .SC_RegGENERAL_data_OutBUS(d1),
        .SC_RegGENERAL_tc_OutHigh(tc1), .SC_RegGENERAL_ovf_OutHigh(ovf1));

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            md[k] = rval[k]; mt[k] = 0; mo[k] = 0; mp[k] = 0;
        end
    endtask

    // Applies one clock edge's worth of rules to instance k, using integer arithmetic.
    task automatic model_edge(input int k);
        int lim;
        lim = int'(lim_bus);
        mt[k] = 0;
        if (clr) begin
            md[k] = rval[k]; mo[k] = 0; mp[k] = 0;
        end else if (ld) begin
            md[k] = int'(ld_bus); mp[k] = 0;
        end else if (en) begin
            mp[k] = (mp[k] + 1) % presc[k];
            if (mp[k] == 0) begin
                if (up) begin
                    if (md[k] < lim) md[k] = md[k] + 1;
                    else begin md[k] = sat ? lim : 0; mt[k] = 1; mo[k] = 1; end
                end else begin
                    if (md[k] > lim) md[k] = lim;
                    else if (md[k] == 0) begin md[k] = sat ? 0 : lim; mt[k] = 1; mo[k] = 1; end
                    else md[k] = md[k] - 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("data0", int'(d0), md[0]);
        check_val("tc0", int'(tc0), mt[0]);
        check_val("ovf0", int'(ovf0), mo[0]);
        check_val("data1", int'(d1), md[1]);
        check_val("tc1", int'(tc1), mt[1]);
        check_val("ovf1", int'(ovf1), mo[1]);
    endtask

    // Called at a falling edge: drive inputs, advance model, wait one cycle, check.
    task automatic tick(input bit c, input bit l, input int lv, input bit e,
                        input bit u, input bit s, input int lm);
        clr = c; ld = l; ld_bus = 4'(lv); en = e; up = u; sat = s; lim_bus = 4'(lm);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int lim_r;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_data0", int'(d0), 0);
        check_val("rst_data1", int'(d1), 2);
        check_val("rst_tc", int'(tc0), 0);
        check_val("rst_ovf", int'(ovf0), 0);
        rst = 1'b0;

        // Up, wrap, limit 9 for 12 steps
        for (int i = 1; i <= 12; i++) begin
            tick(0, 0, 0, 1, 1, 0, 9);
            check_val("t1_data", int'(d0), i % 10);
            check_val("t1_tc", int'(tc0), (i == 10) ? 1 : 0);
        end
        check_val("t1_ovf", int'(ovf0), 1);

        // Saturate: load 8 then three steps
        tick(0, 1, 8, 0, 1, 1, 9);
        check_val("t2_load", int'(d0), 8);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 1, 1, 1, 9);
            check_val("t2_data", int'(d0), 9);
            check_val("t2_tc", int'(tc0), (i >= 2) ? 1 : 0);
        end

        // Down, wrap from 0; then load above limit and step down
        tick(1, 0, 0, 0, 0, 0, 5);
        check_val("t3_clr_ovf", int'(ovf0), 0);
        tick(0, 0, 0, 1, 0, 0, 5);
        check_val("t3_wrap_data", int'(d0), 5);
        check_val("t3_wrap_tc", int'(tc0), 1);
        tick(0, 1, 12, 0, 0, 0, 5);
        check_val("t3_load12", int'(d0), 12);
        tick(0, 0, 0, 1, 0, 0, 5);
        check_val("t3_snap_data", int'(d0), 5);
        check_val("t3_snap_tc", int'(tc0), 0);

        // Prescaler 3 on instance 1
        tick(0, 1, 0, 0, 1, 0, 15);
        for (int i = 1; i <= 9; i++) begin
            tick(0, 0, 0, 1, 1, 0, 15);
            check_val("t4_data1", int'(d1), i / 3);
        end
        tick(0, 0, 0, 1, 1, 0, 15);
        tick(0, 0, 0, 0, 1, 0, 15);
        tick(0, 0, 0, 0, 1, 0, 15);
        tick(0, 0, 0, 1, 1, 0, 15);
        check_val("t4_hold1", int'(d1), 3);
        tick(0, 0, 0, 1, 1, 0, 15);
        check_val("t4_step1", int'(d1), 4);

        // Clear beats load
        tick(0, 1, 7, 0, 1, 0, 15);
        check_val("t5_pre_data", int'(d0), 7);
        check_val("t5_pre_ovf", int'(ovf0), 1);
        tick(1, 1, 9, 1, 1, 0, 15);
        check_val("t5_data0", int'(d0), 0);
        check_val("t5_data1", int'(d1), 2);
        check_val("t5_ovf", int'(ovf0), 0);

        // Async reset between edges mid-count
        tick(0, 0, 0, 1, 1, 0, 3);
        tick(0, 0, 0, 1, 1, 0, 3);
        tick(0, 0, 0, 1, 1, 0, 3);
        tick(0, 0, 0, 1, 1, 0, 3);
        #3 rst = 1'b1;
        #1;
        check_val("t6_data0", int'(d0), 0);
        check_val("t6_data1", int'(d1), 2);
        check_val("t6_tc", int'(tc0), 0);
        check_val("t6_ovf", int'(ovf0), 0);
        #2 rst = 1'b0;
        model_reset();
        tick(0, 0, 0, 1, 1, 0, 3);
        check_val("t6_resume", int'(d0), 1);

        // Randomized traffic against the model
        lim_r = 9;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) lim_r = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lim_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
